uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that is the far end of the existing UART transmitter link. It oversamples the serial line RX_IN, detects and qualifies the start bit, majority-samples each data/parity/stop bit, checks parity and stop, and presents the deserialized word with a one-cycle valid strobe. It sits at the chip-side end of the serial link and feeds the register/FIFO layer. Frame format matches the transmitter: 1 start (0), DATA_WIDTH data bits LSB first, optional parity, 1 stop (1).

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of the RX_Prescale input

Ports:
RX_CLK  input  1  oversampling clock
RX_RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to RX_CLK
RX_Prescale  input  PRESCALE_WIDTH  RX_CLK cycles per bit; legal 8, 16, 32
RX_Parity_Enable  input  1  1 = parity bit present
RX_Parity_Type  input  1  0 = even, 1 = odd
RX_P_Data  output  DATA_WIDTH  last good received word
RX_Data_Valid  output  1  one-cycle strobe, RX_P_Data updated
RX_Parity_Error  output  1  one-cycle strobe, parity mismatch
RX_Stop_Error  output  1  one-cycle strobe, stop bit sampled 0
RX_Busy  output  1  high while a frame is in progress

Behaviour:
- Reset (async, RX_RST=0): state IDLE, counters 0, synchronizer flops 1. RX_P_Data=0, RX_Data_Valid=0, RX_Parity_Error=0, RX_Stop_Error=0, RX_Busy=0. Reset mid-frame abandons the frame with no strobes.
- RX_IN passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized line rx_s.
- Config capture: RX_Prescale (P), RX_Parity_Enable and RX_Parity_Type are latched on the IDLE->START transition. Changes mid-frame have no effect.
- edge_cnt runs 0..P-1 per bit. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority.
- FSM:
  - IDLE: RX_Busy=0. If rx_s=0, go to START next cycle with edge_cnt=1; the detection cycle counts as edge 0.
  - START: at edge_cnt=P-1, a majority of 0 goes to DATA. A majority of 1 is a glitch and returns to IDLE with no strobes.
  - DATA: the majority bit is shifted in LSB first. At edge_cnt=P-1 of bit DATA_WIDTH-1, go to PARITY if enabled, else STOP.
  - PARITY: expected bit = XOR(data) XOR RX_Parity_Type. Store the mismatch flag; at edge_cnt=P-1 go to STOP.
  - STOP: the cycle after the third sample (edge_cnt=P/2+2), the frame completes:
    - stop=1 and no parity mismatch: RX_P_Data <= shift register, RX_Data_Valid=1 for one cycle.
    - otherwise: no valid, RX_P_Data holds. RX_Parity_Error and/or RX_Stop_Error pulse for that one cycle (both may pulse together).
    - Go to IDLE the same cycle.
  - Completing mid-stop lets a back-to-back start edge be detected with zero idle gap.
- RX_Busy=1 in START, DATA, PARITY and STOP.
- Latency: let T be the first RX_CLK edge sampling RX_IN=0 for the start bit. The completion strobe is high in cycle T + 9P + P/2 + 4 without parity, and T + 10P + P/2 + 4 with parity (DATA_WIDTH=8).
- A line stuck low after a stop error is treated as a new start bit. This is legal behaviour.
- Non-legal P values: behaviour undefined; not verified.

Test Plan:
1. P=8, parity off, frame 0xE7 (bits 1,1,1,0,0,1,1,1 LSB first) -> RX_Data_Valid one cycle at T+80, RX_P_Data=0xE7, both error flags 0, RX_Busy high from T+3 until completion.
2. P=16, odd parity, 0xE7 with parity bit 1 -> valid, data 0xE7. Then even parity, 0xE7 with parity bit 1 (wrong) -> RX_Parity_Error one cycle, no valid, RX_P_Data stays 0xE7.
3. P=8, frame 0x55 with stop bit driven 0 -> RX_Stop_Error one cycle, no valid, RX_P_Data unchanged. Line then returned high -> IDLE, RX_Busy=0.
4. P=16, RX_IN low for 3 clocks then high -> START rejects as glitch, back to IDLE, no strobes, RX_P_Data unchanged. Single-clock low pulse mid data bit -> majority masks it, correct word received.
5. P=32, even parity, back-to-back 0xE7 then 0x38 with zero idle gap -> two valid strobes, data 0xE7 then 0x38, no errors. Driving a single-cycle glitch inside the 3-sample window of one bit still yields the correct word.
6. RX_RST asserted during DATA of a frame -> all outputs 0 immediately. After release with the line idle, a new 0xA5 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, qualifies the start bit, majority-samples every bit,
// checks parity and stop, and strobes the completed word for one cycle.
module uart_rx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      RX_CLK,
    input  logic                      RX_RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] RX_Prescale,
    input  logic                      RX_Parity_Enable,
    input  logic                      RX_Parity_Type,
    output logic [DATA_WIDTH-1:0]     RX_P_Data,
    output logic                      RX_Data_Valid,
    output logic                      RX_Parity_Error,
    output logic                      RX_Stop_Error,
    output logic                      RX_Busy
);

    localparam int unsigned BitCntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] One     = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] Two     = PRESCALE_WIDTH'(2);
    localparam logic [BitCntWidth-1:0]    BitOne  = BitCntWidth'(1);
    localparam logic [BitCntWidth-1:0]    BitLast = BitCntWidth'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                    state_q, state_d;
    logic                      sync1_q, sync2_q;
    logic                      rx_s;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BitCntWidth-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]                samp_q, samp_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_type_q, par_type_d;
    logic                      par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;
    logic                      busy_q, busy_d;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      last_edge;
    logic                      stop_done;
    logic                      maj;

    assign rx_s      = sync2_q;
    assign half      = prescale_q >> 1;
    assign last_edge = (edge_cnt_q == (prescale_q - One));
    assign stop_done = (edge_cnt_q == (half + Two));
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);

    always_ff @(posedge RX_CLK or negedge RX_RST) begin
        if (!RX_RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        busy_d     = (state_q != StIdle);

        if (state_q != StIdle) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + One;
            if (edge_cnt_q == (half - One)) samp_d[0] = rx_s;
            if (edge_cnt_q == half)         samp_d[1] = rx_s;
            if (edge_cnt_q == (half + One)) samp_d[2] = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                // The detection cycle is edge 0 of the start bit.
                if (!rx_s) begin
                    state_d    = StStart;
                    edge_cnt_d = One;
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    prescale_d = RX_Prescale;
                    par_en_d   = RX_Parity_Enable;
                    par_type_d = RX_Parity_Type;
                end
            end
            StStart: begin
                if (last_edge) state_d = maj ? StIdle : StData;
            end
            StData: begin
                if (last_edge) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = maj;
                    if (bit_cnt_q == BitLast) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitOne;
                    end
                end
            end
            StParity: begin
                if (last_edge) begin
                    par_err_d = (maj != ((^shift_q) ^ par_type_q));
                    state_d   = StStop;
                end
            end
            StStop: begin
                // Finish mid-stop so a back-to-back start edge is not missed.
                if (stop_done) begin
                    if (maj && !par_err_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        perr_d = par_err_q;
                        serr_d = !maj;
                    end
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign RX_P_Data       = data_q;
    assign RX_Data_Valid   = valid_q;
    assign RX_Parity_Error = perr_q;
    assign RX_Stop_Error   = serr_q;
    assign RX_Busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level outcome model.
module tb_uart_rx;

    logic       RX_CLK;
    logic       RX_RST;
    logic       RX_IN;
    logic [5:0] RX_Prescale;
    logic       RX_Parity_Enable;
    logic       RX_Parity_Type;
    logic [7:0] RX_P_Data;
    logic       RX_Data_Valid;
    logic       RX_Parity_Error;
    logic       RX_Stop_Error;
    logic       RX_Busy;

    uart_rx #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .RX_CLK          (RX_CLK),
        .RX_RST          (RX_RST),
        .RX_IN           (RX_IN),
        .RX_Prescale     (RX_Prescale),
        .RX_Parity_Enable(RX_Parity_Enable),
        .RX_Parity_Type  (RX_Parity_Type),
        .RX_P_Data       (RX_P_Data),
        .RX_Data_Valid   (RX_Data_Valid),
        .RX_Parity_Error (RX_Parity_Error),
        .RX_Stop_Error   (RX_Stop_Error),
        .RX_Busy         (RX_Busy)
    );

    typedef struct {
        int         cyc;
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         cyc;
    int         errors;
    int         checks;
    logic [7:0] mdl_data;

    initial begin
        RX_CLK = 1'b0;
        forever #5 RX_CLK = ~RX_CLK;
    end

    initial cyc = 0;
    always @(posedge RX_CLK) cyc <= cyc + 1;

    always @(negedge RX_CLK) begin
        if (RX_Data_Valid || RX_Parity_Error || RX_Stop_Error) begin
            ev_t e;
            e.cyc = cyc;
            e.v   = RX_Data_Valid;
            e.pe  = RX_Parity_Error;
            e.se  = RX_Stop_Error;
            e.d   = RX_P_Data;
            obs_q.push_back(e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge RX_CLK);
            #1;
        end
    endtask

    // Drive one frame; gbit/goff invert the line for one cycle of bit gbit (gbit<0: none).
    task automatic send_frame(input logic [7:0] data, input int p, input logic pe,
                              input logic pt, input logic pbit, input logic stopb,
                              input int gbit, input int goff, input bit chk_busy);
        logic bits[11];
        int   nb;
        int   t0;
        ev_t  e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (pe) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = stopb;
        nb++;
        RX_Prescale      = 6'(p);
        RX_Parity_Enable = pe;
        RX_Parity_Type   = pt;
        t0 = cyc + 1;
        e.cyc = t0 + (pe ? 10 : 9) * p + p / 2 + 4;
        e.pe  = pe && (pbit != ((^data) ^ pt));
        e.se  = !stopb;
        e.v   = !e.pe && !e.se;
        if (e.v) mdl_data = data;
        e.d   = mdl_data;
        exp_q.push_back(e);
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < p; k++) begin
                RX_IN = bits[j] ^ ((j == gbit) && (k == goff));
                if (j == 1 && k == 0) begin
                    RX_Prescale      = 6'(8 << $urandom_range(0, 2));
                    RX_Parity_Enable = 1'($urandom);
                    RX_Parity_Type   = 1'($urandom);
                end
                @(posedge RX_CLK);
                #1;
                if (chk_busy && j == 0 && k == 2) check("busy_before_T3", RX_Busy, 0);
                if (chk_busy && j == 0 && k == 3) check("busy_at_T3", RX_Busy, 1);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            check({tag, "_valid"}, obs_q[i].v, exp_q[i].v);
            check({tag, "_perr"}, obs_q[i].pe, exp_q[i].pe);
            check({tag, "_serr"}, obs_q[i].se, exp_q[i].se);
            check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int p;
        logic [7:0] d;
        logic pe, pt, pb, sb;
        errors           = 0;
        checks           = 0;
        mdl_data         = 8'h00;
        RX_RST           = 1'b0;
        RX_IN            = 1'b1;
        RX_Prescale      = 6'd8;
        RX_Parity_Enable = 1'b0;
        RX_Parity_Type   = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        check("rst_data", RX_P_Data, 0);
        check("rst_valid", RX_Data_Valid, 0);
        check("rst_perr", RX_Parity_Error, 0);
        check("rst_serr", RX_Stop_Error, 0);
        check("rst_busy", RX_Busy, 0);
        @(negedge RX_CLK);
        RX_RST = 1'b1;
        idle(4);

        // P=8, no parity, 0xE7 with busy timing
        send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        idle(12);
        compare_events("t1");
        check("t1_busy_idle", RX_Busy, 0);

        // P=16 odd parity good, then even parity with wrong parity bit
        send_frame(8'hE7, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(3);
        send_frame(8'hE7, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(20);
        compare_events("t2");
        check("t2_data_held", RX_P_Data, 8'hE7);

        // P=8 stop bit low
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
        idle(40);
        compare_events("t3");
        check("t3_busy", RX_Busy, 0);
        check("t3_data_held", RX_P_Data, 8'hE7);

        // P=16 short low pulse rejected at start, then masked mid-bit pulse
        RX_Prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (3) begin
            @(posedge RX_CLK);
            #1;
        end
        idle(40);
        compare_events("t4_glitch");
        check("t4_busy", RX_Busy, 0);
        check("t4_data_held", RX_P_Data, 8'hE7);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8, 1'b0);
        idle(20);
        compare_events("t4_frame");

        // P=32 even parity back-to-back, glitch in the sample window of one bit
        send_frame(8'hE7, 32, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        send_frame(8'h38, 32, 1'b1, 1'b0, 1'b1, 1'b1, 4, 17, 1'b0);
        idle(40);
        compare_events("t5");

        // Reset in the middle of DATA
        RX_Prescale      = 6'd8;
        RX_Parity_Enable = 1'b0;
        RX_IN            = 1'b0;
        repeat (8) begin
            @(posedge RX_CLK);
            #1;
        end
        for (int i = 0; i < 24; i++) begin
            RX_IN = 1'(i / 8);
            @(posedge RX_CLK);
            #1;
        end
        #2;
        RX_RST = 1'b0;
        #1;
        check("t6_rst_data", RX_P_Data, 0);
        check("t6_rst_valid", RX_Data_Valid, 0);
        check("t6_rst_perr", RX_Parity_Error, 0);
        check("t6_rst_serr", RX_Stop_Error, 0);
        check("t6_rst_busy", RX_Busy, 0);
        mdl_data = 8'h00;
        RX_IN    = 1'b1;
        repeat (3) @(posedge RX_CLK);
        @(negedge RX_CLK);
        RX_RST = 1'b1;
        idle(4);
        compare_events("t6_abort");
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(12);
        compare_events("t6");

        // Randomized frames
        for (int n = 0; n < 10; n++) begin
            p  = 8 << $urandom_range(0, 2);
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            pb = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, p, pe, pt, pb, sb, $urandom_range(1, 8),
                       p / 2 - 1 + $urandom_range(0, 2), 1'b0);
            if (sb) idle($urandom_range(0, 3));
            else    idle(2 * p + 4);
        end
        idle(80);
        compare_events("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
